// File: rtl/text_line_buffer_if.sv
// Bundles the byte-input, overlay-lookup and status signals of text_line_buffer.
// The master drives the bytes and lookups; the slave is the line buffer.
interface text_line_buffer_if;
  logic [4:0]  char_xy;
  logic [3:0]  char_line;
  logic [10:0] font_addr;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        clear_req;
  logic        frame_tick;
  logic [4:0]  cursor_pos;

  modport master (
    output char_xy, char_line, wr_data, wr_valid, clear_req, frame_tick,
    input  font_addr, wr_ready, cursor_pos
  );

  modport slave (
    input  char_xy, char_line, wr_data, wr_valid, clear_req, frame_tick,
    output font_addr, wr_ready, cursor_pos
  );
endinterface

// File: rtl/text_line_buffer.sv
// One-line text store with a blinking cursor.
// It turns overlay cell lookups into registered font ROM addresses {code, line}.
module text_line_buffer #(
  parameter int unsigned LINE_LEN    = 30,
  parameter int unsigned BLINK_HALF  = 30,
  parameter logic [6:0]  CURSOR_CODE = 7'h5F
) (
  input logic               pclk,
  input logic               rst_n,
  text_line_buffer_if.slave bus
);

  localparam logic [6:0]  Blank     = 7'h20;
  localparam logic [4:0]  LastIdx   = 5'(LINE_LEN - 1);
  localparam int unsigned BlinkW    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        cursor_q, cursor_d;
  logic [6:0]        cell_q [LINE_LEN];
  logic [6:0]        cell_d [LINE_LEN];
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic [10:0]       font_addr_q, font_addr_d;
  logic              accept;
  logic [6:0]        rd_code;

  // Line state: clear sweep and byte handling
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cursor_d = cursor_q;
    cell_d   = cell_q;
    accept   = 1'b0;
    unique case (state_q)
      StClear: begin
        cell_d[idx_q] = Blank;
        if (bus.clear_req) begin
          idx_d = '0;
        end else if (idx_q == LastIdx) begin
          state_d  = StIdle;
          idx_d    = '0;
          cursor_d = '0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      StIdle: begin
        if (bus.clear_req) begin
          state_d = StClear;
          idx_d   = '0;
        end else if (bus.wr_valid) begin
          accept = 1'b1;
          if (bus.wr_data >= 8'h20 && bus.wr_data <= 8'h7E) begin
            cell_d[cursor_q] = bus.wr_data[6:0];
            cursor_d = (cursor_q == LastIdx) ? 5'd0 : cursor_q + 5'd1;
          end else if (bus.wr_data == 8'h08) begin
            if (cursor_q != 5'd0) begin
              cursor_d = cursor_q - 5'd1;
              cell_d[cursor_q - 5'd1] = Blank;
            end
          end else if (bus.wr_data == 8'h0D) begin
            cursor_d = '0;
          end
        end
      end
    endcase
  end

  // Blink timing; typing keeps the cursor visible
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (accept) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (bus.frame_tick) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Lookup reads the pre-edge cell contents, so same-cycle writes show old data
  always_comb begin
    rd_code = Blank;
    if (state_q == StIdle && {1'b0, bus.char_xy} < 6'(LINE_LEN)) begin
      if (bus.char_xy == cursor_q && blink_on_q) begin
        rd_code = CURSOR_CODE;
      end else begin
        rd_code = cell_q[bus.char_xy];
      end
    end
    font_addr_d = {rd_code, bus.char_line};
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      idx_q       <= '0;
      cursor_q    <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      font_addr_q <= '0;
      for (int unsigned i = 0; i < LINE_LEN; i++) begin
        cell_q[i] <= Blank;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cursor_q    <= cursor_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      font_addr_q <= font_addr_d;
      cell_q      <= cell_d;
    end
  end

  assign bus.font_addr  = font_addr_q;
  assign bus.wr_ready   = (state_q == StIdle);
  assign bus.cursor_pos = cursor_q;

endmodule

// File: tb/tb_text_line_buffer.sv
// Bench for text_line_buffer: directed vector table, corner sequences and
// random traffic checked against a line-of-characters reference model.
module tb_text_line_buffer;
  localparam int LineLen   = 30;
  localparam int BlinkHalf = 30;

  logic clk;
  logic rst_n;
  text_line_buffer_if tif ();

  text_line_buffer #(
    .LINE_LEN   (30),
    .BLINK_HALF (30),
    .CURSOR_CODE(7'h5F)
  ) dut (
    .pclk (clk),
    .rst_n(rst_n),
    .bus  (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: character array, cursor column, remaining clear cycles,
  // frame ticks seen since the last accepted byte (or reset).
  int m_cell [LineLen];
  int m_cur;
  int m_clear_left;
  int m_ticks;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LineLen; i++) m_cell[i] = 32'h20;
    m_cur        = 0;
    m_clear_left = LineLen;
    m_ticks      = 0;
  endtask

  function automatic int model_font(input int xy, input int ln);
    int code;
    if (m_clear_left != 0 || xy >= LineLen) code = 32'h20;
    else if (xy == m_cur && ((m_ticks / BlinkHalf) % 2) == 0) code = 32'h5F;
    else code = m_cell[xy];
    return (code << 4) | ln;
  endfunction

  // One clock: apply inputs, check ready, advance model, check registered outputs.
  task automatic cycle(input logic [7:0] d, input logic v, input logic clr,
                       input logic tick, input logic [4:0] xy, input logic [3:0] ln);
    int  exp_font;
    bit  idle;
    bit  acc;
    tif.wr_data    = d;
    tif.wr_valid   = v;
    tif.clear_req  = clr;
    tif.frame_tick = tick;
    tif.char_xy    = xy;
    tif.char_line  = ln;
    idle = (m_clear_left == 0);
    #1;
    chk("wr_ready", int'(tif.wr_ready), int'(idle));
    exp_font = model_font(int'(xy), int'(ln));
    @(posedge clk);
    #1;
    acc = 1'b0;
    if (clr) begin
      for (int i = 0; i < LineLen; i++) m_cell[i] = 32'h20;
      m_clear_left = LineLen;
    end else if (!idle) begin
      m_clear_left--;
      if (m_clear_left == 0) m_cur = 0;
    end else if (v) begin
      acc = 1'b1;
      if (d >= 8'h20 && d <= 8'h7E) begin
        m_cell[m_cur] = int'(d);
        m_cur = (m_cur == LineLen - 1) ? 0 : m_cur + 1;
      end else if (d == 8'h08) begin
        if (m_cur > 0) begin
          m_cur--;
          m_cell[m_cur] = 32'h20;
        end
      end else if (d == 8'h0D) begin
        m_cur = 0;
      end
    end
    if (acc) m_ticks = 0;
    else if (tick) m_ticks++;
    chk("font_addr", int'(tif.font_addr), exp_font);
    chk("cursor_pos", int'(tif.cursor_pos), m_cur);
  endtask

  task automatic nop(input logic [4:0] xy, input logic [3:0] ln);
    cycle(8'h00, 1'b0, 1'b0, 1'b0, xy, ln);
  endtask

  task automatic wait_ready(input string name, input int exp_len);
    int n = 0;
    while (!tif.wr_ready && n < 100) begin
      nop(5'($urandom % 32), 4'($urandom % 16));
      n++;
    end
    chk(name, n, exp_len);
  endtask

  typedef struct packed {
    logic [7:0]  data;
    logic        valid;
    logic [4:0]  xy;
    logic [3:0]  ln;
    logic [10:0] exp_font;
    logic [4:0]  exp_cur;
  } vec_t;

  vec_t vecs [20];

  initial begin
    vecs = '{
      '{8'h41, 1'b1, 5'd3,  4'd5,  11'h205, 5'd1},  // 'A', blank lookup
      '{8'h42, 1'b1, 5'd0,  4'd2,  11'h412, 5'd2},  // 'B'
      '{8'h00, 1'b0, 5'd1,  4'd2,  11'h422, 5'd2},
      '{8'h00, 1'b0, 5'd2,  4'd0,  11'h5F0, 5'd2},  // cursor cell
      '{8'h08, 1'b1, 5'd1,  4'd0,  11'h420, 5'd1},  // backspace, old value read
      '{8'h00, 1'b0, 5'd1,  4'd0,  11'h5F0, 5'd1},
      '{8'h0D, 1'b1, 5'd31, 4'd7,  11'h207, 5'd0},  // CR, out-of-range column
      '{8'h08, 1'b1, 5'd0,  4'd1,  11'h5F1, 5'd0},  // backspace at 0
      '{8'h85, 1'b1, 5'd0,  4'd1,  11'h5F1, 5'd0},  // bit7 set ignored
      '{8'h07, 1'b1, 5'd0,  4'd1,  11'h5F1, 5'd0},
      '{8'h58, 1'b1, 5'd0,  4'd1,  11'h5F1, 5'd1},  // 'X'
      '{8'h59, 1'b1, 5'd0,  4'd3,  11'h583, 5'd2},  // 'Y'
      '{8'h0D, 1'b1, 5'd1,  4'd3,  11'h593, 5'd0},
      '{8'h5A, 1'b1, 5'd1,  4'd4,  11'h594, 5'd1},  // 'Z' over 'X'
      '{8'h00, 1'b0, 5'd0,  4'd4,  11'h5A4, 5'd1},
      '{8'h1F, 1'b1, 5'd0,  4'd0,  11'h5A0, 5'd1},  // just below printable
      '{8'h7F, 1'b1, 5'd2,  4'd0,  11'h200, 5'd1},  // just above printable
      '{8'h7E, 1'b1, 5'd1,  4'd0,  11'h5F0, 5'd2},  // '~' highest printable
      '{8'h00, 1'b0, 5'd1,  4'd0,  11'h7E0, 5'd2},
      '{8'h20, 1'b1, 5'd29, 4'd15, 11'h20F, 5'd3}   // space, last column
    };
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    tif.wr_data    = '0;
    tif.wr_valid   = 1'b0;
    tif.clear_req  = 1'b0;
    tif.frame_tick = 1'b0;
    tif.char_xy    = '0;
    tif.char_line  = '0;
    model_reset();
    #12;
    chk("reset_font_addr", int'(tif.font_addr), 0);
    chk("reset_wr_ready", int'(tif.wr_ready), 0);
    chk("reset_cursor", int'(tif.cursor_pos), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("startup_clear_len", LineLen);

    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].data, vecs[i].valid, 1'b0, 1'b0, vecs[i].xy, vecs[i].ln);
      chk("vec_font_addr", int'(tif.font_addr), int'(vecs[i].exp_font));
      chk("vec_cursor", int'(tif.cursor_pos), int'(vecs[i].exp_cur));
    end

    // Wrap: 31 chars from column 0 land the last one in cell 0
    cycle(8'h0D, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0);
    for (int i = 0; i < 31; i++) cycle(8'h61, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0);
    chk("wrap_cursor", int'(tif.cursor_pos), 1);
    nop(5'd0, 4'd0);
    chk("wrap_cell0", int'(tif.font_addr), 32'h610);
    nop(5'd29, 4'd0);
    chk("wrap_cell29", int'(tif.font_addr), 32'h610);

    // Clear wins over a same-cycle byte
    cycle(8'h51, 1'b1, 1'b1, 1'b0, 5'd1, 4'd0);
    wait_ready("clear_len", LineLen);
    nop(5'd1, 4'd9);
    chk("clear_cell1", int'(tif.font_addr), 32'h209);
    chk("clear_cursor", int'(tif.cursor_pos), 0);

    // Blink: 30 ticks on, 30 ticks off, then on again
    for (int i = 0; i < 2 * BlinkHalf; i++) begin
      cycle(8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 4'd0);
      chk("blink_phase", int'(tif.font_addr), (i < BlinkHalf) ? 32'h5F0 : 32'h200);
    end
    nop(5'd0, 4'd0);
    chk("blink_reon", int'(tif.font_addr), 32'h5F0);

    // Typing forces the cursor visible again mid-off-phase
    for (int i = 0; i < BlinkHalf + 3; i++) cycle(8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 4'd0);
    cycle(8'h4B, 1'b1, 1'b0, 1'b0, 5'd1, 4'd0);
    nop(5'd1, 4'd0);
    chk("blink_accept_on", int'(tif.font_addr), 32'h5F0);

    // Async reset mid-clear
    cycle(8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 4'd0);
    for (int i = 0; i < 3; i++) nop(5'd0, 4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midclear_rst_font", int'(tif.font_addr), 0);
    chk("midclear_rst_ready", int'(tif.wr_ready), 0);
    chk("midclear_rst_cursor", int'(tif.cursor_pos), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("reclear_len", LineLen);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      int r;
      r = int'($urandom % 8);
      if (r == 0) d = 8'h08;
      else if (r == 1) d = 8'h0D;
      else if (r == 2) d = 8'($urandom);
      else d = 8'(8'h20 + ($urandom % 95));
      cycle(d, 1'($urandom % 5 < 2), 1'($urandom % 100 == 0), 1'($urandom % 3 == 0),
            5'($urandom % 32), 4'($urandom % 16));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
